// File: rtl/rgb565_frame_reader.sv
`timescale 1ns/1ps
// rgb565_frame_reader: reads one RGB565 frame buffer in address order and streams it out as RGB888.
// Latency: first o_valid two enabled cycles after i_start is sampled, then one pixel per enabled cycle.
// Backpressure: i_ready low stalls a 2-entry output FIFO; reads are throttled so it never overflows.
//
// Ports:
//   iClk, iRst_n       clock (rising edge), asynchronous active-low reset
//   i_Clk_en           clock enable; nothing advances on edges where it is 0
//   i_start            frame request, only honoured in IDLE
//   o_rd_en/o_rd_addr  frame-buffer read strobe and address
//   i_rd_data          RGB565 read data, returned on the enabled edge after the read is issued
//   o_data_rgb888      R[23:16] G[15:8] B[7:0], qualified by o_valid, accepted with i_ready
//   o_eol              marks the last pixel of each line
//   o_busy             high outside IDLE
//   o_frame_done       one-enabled-cycle pulse once the last pixel has left the FIFO
//
// Build option: define RGB_EXPAND_REPLICATE_EN for bit-replicating colour expansion;
// the default build zero-fills the low bits.

// sync_fifo: small synchronous FIFO with show-ahead read data.
// Latency: written data is visible on o_rd_dat the edge after the write.
// Backpressure: writes are dropped only when full with no simultaneous read; callers must avoid that.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       i_Clk_en,
  input  logic                       i_wr_vld,
  input  logic [WIDTH-1:0]           i_wr_dat,
  input  logic                       i_rd_rdy,
  output logic                       o_rd_vld,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign pop      = i_Clk_en & i_rd_rdy & (count != '0);
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push     = i_Clk_en & i_wr_vld & ((count != CW'(DEPTH)) | pop);
  assign o_rd_vld = (count != '0);
  assign o_rd_dat = mem[rd_ptr];
  assign o_count  = count;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_wr_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push & ~pop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module rgb565_frame_reader #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  i_Clk_en,
  input  logic                  i_start,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [15:0]           i_rd_data,
  output logic [23:0]           o_data_rgb888,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_eol,
  output logic                  o_busy,
  output logic                  o_frame_done
);
  localparam int FRAME_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int COL_W       = $clog2(H_ACTIVE + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_DEPTH - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [COL_W-1:0]      col;          // position of the next issued read within its line
  logic                  inflight;     // a read was issued on the previous enabled edge
  logic                  inflight_eol; // that read is the last pixel of a line
  logic                  fifo_vld;
  logic [16:0]           fifo_head;    // {eol, rgb565}
  logic [1:0]            fifo_count;
  logic                  xfer;
  logic [2:0]            credit_use;
  logic [4:0]            r5;
  logic [5:0]            g6;
  logic [4:0]            b5;
  logic                  frame_done;

  assign xfer = i_Clk_en & fifo_vld & i_ready;

  // FIFO slots already spoken for once this edge's transfer has left. Counting the
  // outgoing pixel lets a read issue every enabled cycle while the consumer keeps up,
  // and the sum can never exceed the two FIFO entries.
  assign credit_use = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, xfer};
  assign o_rd_en    = (state == RUN) & i_Clk_en & (credit_use < 3'd2);
  assign o_rd_addr  = rd_addr;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= IDLE;
      rd_addr      <= '0;
      col          <= '0;
      inflight     <= 1'b0;
      inflight_eol <= 1'b0;
      frame_done   <= 1'b0;
    end else if (i_Clk_en) begin
      frame_done   <= 1'b0;
      inflight     <= o_rd_en;
      inflight_eol <= (col == LAST_COL);
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= RUN;
            rd_addr <= '0;
            col     <= '0;
          end
        end
        RUN: begin
          if (o_rd_en) begin
            col <= (col == LAST_COL) ? '0 : col + 1'b1;
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              state   <= DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (17),
    .DEPTH (2)
  ) u_out_fifo (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .i_Clk_en (i_Clk_en),
    .i_wr_vld (inflight),
    .i_wr_dat ({inflight_eol, i_rd_data}),
    .i_rd_rdy (i_ready),
    .o_rd_vld (fifo_vld),
    .o_rd_dat (fifo_head),
    .o_count  (fifo_count)
  );

  assign r5 = fifo_head[15:11];
  assign g6 = fifo_head[10:5];
  assign b5 = fifo_head[4:0];

`ifdef RGB_EXPAND_REPLICATE_EN
  assign o_data_rgb888 = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
`else
  assign o_data_rgb888 = {r5, 3'b000, g6, 2'b00, b5, 3'b000};
`endif

  assign o_valid      = fifo_vld;
  assign o_eol        = fifo_vld & fifo_head[16];
  assign o_busy       = (state != IDLE);
  assign o_frame_done = frame_done;
endmodule

// File: doc/rgb565_frame_reader.md
RGB565_FRAME_READER -- requirements
Module: rgb565_frame_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, lines per frame; FRAME_DEPTH = H_ACTIVE*V_ACTIVE = 130560.
REQ-003 SHALL have parameter ADDR_WIDTH, default 17, frame-buffer address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: iClk  input  1  clock, rising edge; iRst_n  input  1  async active-low reset.
REQ-005 i_Clk_en  input  1  clock enable; state advances only on iClk edges where it is 1.
REQ-006 i_start  input  1  frame-read request, sampled in IDLE only.
REQ-007 o_rd_en  output  1  frame-buffer read strobe.
REQ-008 o_rd_addr  output  ADDR_WIDTH  frame-buffer read address.
REQ-009 i_rd_data  input  16  RGB565 read data, R[15:11] G[10:5] B[4:0].
REQ-010 o_data_rgb888  output  24  pixel, R[23:16] G[15:8] B[7:0].
REQ-011 o_valid  output  1  o_data_rgb888 valid.
REQ-012 i_ready  input  1  downstream accept.
REQ-013 o_eol  output  1  qualifies o_data as the last pixel of a line.
REQ-014 o_busy  output  1  high when not IDLE.
REQ-015 o_frame_done  output  1  one-enabled-cycle pulse after the last pixel is accepted.

Function
REQ-016 A transfer SHALL occur on an enabled edge with o_valid=1 and i_ready=1.
REQ-017 FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on i_start=1, with read address and line counter cleared to 0.
REQ-018 In RUN, the block SHALL assert o_rd_en only when i_Clk_en=1 and (output FIFO occupancy + reads in flight) < 2.
REQ-019 o_rd_addr SHALL increment by 1 after each issued read; issuing address FRAME_DEPTH-1 SHALL move RUN->DRAIN.
REQ-020 i_rd_data SHALL be captured into a 2-entry output FIFO on the first enabled edge after the edge that sampled o_rd_en=1; i_rd_data is held stable in between.
REQ-021 The FIFO SHALL never overflow and SHALL never drop or duplicate pixels; order SHALL equal address order.
REQ-022 o_data_rgb888 and o_eol SHALL be held stable while o_valid=1 and no transfer occurs.
REQ-023 Simultaneous capture and transfer on a full FIFO SHALL be legal, with occupancy unchanged.
REQ-024 o_eol SHALL be 1 on every H_ACTIVE-th pixel (index mod H_ACTIVE = H_ACTIVE-1).
REQ-025 DRAIN->IDLE SHALL occur when the FIFO is empty and no read is in flight, and o_frame_done SHALL pulse in that same enabled cycle.
REQ-026 i_start in RUN or DRAIN SHALL be ignored.
REQ-027 With i_ready=1 continuously, the first o_valid SHALL occur 2 enabled cycles after i_start is sampled, followed by one pixel per enabled cycle.

Reset
REQ-028 iRst_n=0 SHALL immediately force state IDLE, FIFO empty, in-flight cleared, and counters 0.
REQ-029 Reset SHALL force o_rd_en=0, o_rd_addr=0, o_data_rgb888=0, o_valid=0, o_eol=0, o_busy=0, o_frame_done=0.
REQ-030 Reset mid-frame SHALL abandon the frame; the next i_start restarts at address 0.

Configuration
REQ-031 With macro RGB_EXPAND_REPLICATE_EN defined, expansion SHALL be R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-032 Without RGB_EXPAND_REPLICATE_EN, expansion SHALL zero-fill: R8={R5,3'b0}, G8={G6,2'b0}, B8={B5,3'b0}.

Verification
REQ-033 Memory model returns addr[15:0], i_ready=1, i_Clk_en=1, one i_start -> 130560 pixels in address order, first o_valid 2 cycles after start, o_eol every 480th, exactly one o_frame_done.
REQ-034 Data 0xF800/0x07E0/0x001F/0x8410 -> 0xFF0000/0x00FF00/0x0000FF/0x848284 with the macro; 0xF80000/0x00FC00/0x0000F8/0x808080 without it.
REQ-035 Random 50% i_ready -> identical pixel sequence to REQ-033, outputs stable while stalled, no drop or duplicate.
REQ-036 i_Clk_en high 1 cycle in 3 plus random i_ready -> identical sequence; nothing changes on disabled edges.
REQ-037 i_start pulsed at pixel 1000 -> ignored; iRst_n low at pixel 5000 -> all outputs 0, a new i_start restarts at o_rd_addr=0.
REQ-038 H_ACTIVE=4, V_ACTIVE=2 -> 8 pixels, o_eol on pixels 3 and 7, o_frame_done after pixel 7 is accepted, o_busy=0 afterwards.
